// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM round-robin arbiter.
package sram_arb_pkg;

  localparam int MASK_W     = 4;
  localparam int WORD_W     = 32;
  localparam int ADDR_W_MAX = 32;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Address is carried at full width so the struct is independent of MEM_DEPTH.
  typedef struct packed {
    logic                  we;
    logic [MASK_W-1:0]     mask;
    logic [ADDR_W_MAX-1:0] addr;
    logic [WORD_W-1:0]     wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first eligible index at or above prio,
// wrapping modulo N. Produces a one-hot grant plus the winner index.
module rr_picker #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] prio_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] winner_o,
  output logic          valid_o
);

  always_comb begin
    int idx;
    logic found;
    grant_o  = '0;
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(prio_i) + k) % N;
      if (!found && elig_i[IW'(idx)]) begin
        found              = 1'b1;
        grant_o[IW'(idx)]  = 1'b1;
        winner_o           = IW'(idx);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin sharing of one single-port SRAM between NUM_REQ requesters, with a
// one-entry registered response slot per requester.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int MEM_DEPTH  = 2048,
  parameter  int DATA_WIDTH = 32,
  localparam int AW         = addr_w(MEM_DEPTH),
  localparam int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [MASK_W*NUM_REQ-1:0]     req_mask,
  input  logic [AW*NUM_REQ-1:0]         req_addr,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH*NUM_REQ-1:0] rsp_rdata,
  output logic                          sram_write_en,
  output logic                          sram_read_en,
  output logic [MASK_W-1:0]             sram_mask,
  output logic [AW-1:0]                 sram_address,
  output logic [DATA_WIDTH-1:0]         sram_write_data,
  input  logic [DATA_WIDTH-1:0]         sram_read_data
);

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      winner;
  logic               any_grant;
  logic [IW-1:0]      prio_q, prio_d;
  sram_req_t          reqs [NUM_REQ];
  sram_req_t          sel;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // A full slot may still take a new grant if it is being drained this cycle.
    assign elig[gi] = !reset && req_valid[gi] && (!valid_q || rsp_ready[gi]);

    assign reqs[gi] = '{
      we:    req_we[gi],
      mask:  req_mask[gi*MASK_W +: MASK_W],
      addr:  ADDR_W_MAX'(req_addr[gi*AW +: AW]),
      wdata: req_wdata[gi*DATA_WIDTH +: DATA_WIDTH]
    };

    always_comb begin
      valid_d = valid_q;
      rdata_d = rdata_q;
      if (grant[gi]) begin
        valid_d = 1'b1;
        rdata_d = sel.we ? '0 : sram_read_data;
      end else if (rsp_ready[gi]) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
        rdata_q <= '0;
      end else begin
        valid_q <= valid_d;
        rdata_q <= rdata_d;
      end
    end

    assign rsp_valid[gi]                          = valid_q;
    assign rsp_rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
  end

  rr_picker #(.N(NUM_REQ)) u_picker (
    .elig_i   (elig),
    .prio_i   (prio_q),
    .grant_o  (grant),
    .winner_o (winner),
    .valid_o  (any_grant)
  );

  assign req_ready = grant;
  assign sel       = reqs[winner];

  if (AW < ADDR_W_MAX) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^sel.addr[ADDR_W_MAX-1:AW];
  end

  // Idle cycles drive the SRAM with all zeros; reads never carry a mask.
  always_comb begin
    sram_write_en   = 1'b0;
    sram_read_en    = 1'b0;
    sram_mask       = '0;
    sram_address    = '0;
    sram_write_data = '0;
    if (any_grant) begin
      sram_address = sel.addr[AW-1:0];
      if (sel.we) begin
        sram_write_en   = 1'b1;
        sram_mask       = sel.mask;
        sram_write_data = sel.wdata;
      end else begin
        sram_read_en = 1'b1;
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (any_grant) begin
      prio_d = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= '0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Round-robin arbiter that shares one single-port `mem_sram` instance between `NUM_REQ` requesters, such as instruction fetch, data port and DMA. Each requester issues word-granular read or write requests over a valid/ready handshake. The arbiter grants at most one access per cycle, drives the SRAM control and data lines, and returns the result through a per-requester one-entry registered response slot with backpressure. It sits between the bus-side slave logic and `mem_sram`.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `MEM_DEPTH`, 2048: SRAM depth in words; must match the attached `mem_sram`.
- `DATA_WIDTH`, 32: word width; fixed at 32 because the mask is 4 bytes.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: request valid, one bit per requester.
- `req_ready` out NUM_REQ: request accepted (grant) this cycle.
- `req_we` in NUM_REQ: 1 = write, 0 = read.
- `req_mask` in 4*NUM_REQ: byte enables for requester i at [4i+3:4i].
- `req_addr` in AW*NUM_REQ: word address, where AW = $clog2(MEM_DEPTH).
- `req_wdata` in 32*NUM_REQ: write data.
- `rsp_valid` out NUM_REQ: response slot full.
- `rsp_ready` in NUM_REQ: requester consumes its response.
- `rsp_rdata` out 32*NUM_REQ: read data; 0 for write responses.
- `sram_write_en` out 1: drives `mem_sram` write_en.
- `sram_read_en` out 1: drives `mem_sram` read_en.
- `sram_mask` out 4: drives `mem_sram` mask.
- `sram_address` out AW: drives `mem_sram` address.
- `sram_write_data` out 32: drives `mem_sram` write_data.
- `sram_read_data` in 32: from `mem_sram` read_data (combinational).

## Operation
- **Eligibility.** Requester i is eligible when `req_valid[i]` is high and its slot can accept a new entry: `!rsp_valid[i] || rsp_ready[i]`.
- **Arbitration.** Scan from pointer `prio` upward, modulo NUM_REQ. The first eligible requester wins. At most one `req_ready` bit is high per cycle.
- **Pointer update.** On a grant, `prio` becomes winner+1 (mod NUM_REQ). With no grant, `prio` holds.
- **SRAM drive, granted read.** `sram_read_en`=1, `sram_write_en`=0; address from the winner.
- **SRAM drive, granted write.** `sram_write_en`=1; mask, address and data from the winner.
- **SRAM drive, no grant.** All `sram_*` outputs are 0.
- **Response capture.** At the grant edge, slot[winner] loads `sram_read_data` for a read, or 0 for a write. `rsp_valid[winner]` is set.
- **Slot drain.** A slot clears on `rsp_valid && rsp_ready` unless it is reloaded in the same cycle. Simultaneous drain and reload leaves `rsp_valid` at 1 with the new data.
- **Mask on reads.** The mask is ignored for reads and passed through as 0.
- **Zero mask on writes.** A write with mask 0 is still granted and acknowledged, and leaves memory unchanged.
- **Reset.** While `reset` is high:
  - all `req_ready` are 0 and all `sram_*` outputs are 0, so no SRAM write happens;
  - `prio` is 0, all `rsp_valid` are 0, all `rsp_rdata` are 0.
- **Reset mid-operation.** Reset asserted while slots are full discards the pending responses. Requesters must reissue.

## Timing
- **Grant path.** `req_ready` is combinational from `req_valid`, `rsp_valid` and `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- **Latency.** Response appears 1 cycle after the grant cycle.
- **Throughput.** One access per cycle aggregate. A sole requester with `rsp_ready` held high sustains 1 access per cycle.
- **Write visibility.** A write takes effect at the grant edge. A read of the same address granted in the next cycle returns the new data.
- **Request stability.** `req_*` fields are sampled only in the grant cycle. A requester must hold them stable while `req_valid` is high and `req_ready` is low.
- **Response stability.** `rsp_valid` and `rsp_rdata` are stable until consumed.

## Structure
- **Package `sram_arb_pkg`:**
  - `localparam` `MASK_W`=4 and `WORD_W`=32;
  - function `addr_w(depth)` returning $clog2(depth);
  - typedef struct `sram_req_t` with fields `we`, `mask`, `addr`, `wdata`.
- **Sub-module `rr_picker`:** combinational rotating-priority picker. Inputs are the eligible vector and `prio`; outputs are a one-hot grant and the winner index. It is reusable by other shared-resource arbiters.
- **Top level:** holds the `prio` register, the response slots and the SRAM mux.

## Test plan
- **Reset mid-operation.** Reset asserted for 2 cycles while both slots are full, with `req_valid` high → no `sram_write_en`, `rsp_valid`=0, `prio`=0. After reset, req0 wins first.
- **Single write then read.** req0 writes addr 5, data 0xDEADBEEF, mask 4'hF; next cycle req0 reads addr 5 → `rsp_rdata`=0xDEADBEEF one cycle after that read's grant. The write response has rdata 0.
- **Partial write.** Write 0x11223344 mask 4'b0101 onto a word holding 0xAABBCCDD → a later read returns 0xAA22CC44.
- **Fairness.** Both requesters hold `req_valid` for 6 cycles with `rsp_ready`=1 → grants alternate 0,1,0,1,0,1, 3 each, and SRAM is busy every cycle.
- **Backpressure.** req1 `rsp_ready`=0 with its slot full while req0 and req1 are both valid → req1 is never granted and req0 is granted every cycle. Raising req1 `rsp_ready` → req1 is granted the same cycle, and the slot drains and reloads with `rsp_valid` staying 1.
- **Idle.** No `req_valid` for 4 cycles → all `sram_*` outputs are 0 and `prio` is unchanged.
